// File: rtl/ntt_bu_pipe.sv
// Multi-lane NTT butterfly datapath: CT NTT, GS INTT with fused /2, add/sub, and modular multiply.
// Five register stages with Barrett reduction and a full-pipeline valid/ready stall.
module ntt_bu_pipe #(
  parameter int LANES = 2,
  parameter int W = 25,
  parameter logic [W-1:0] Q = 25'h1FC0001,
  parameter int TAG_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [LANES*W-1:0]    in_a,
  input  logic [LANES*W-1:0]    in_b,
  input  logic [LANES*W-1:0]    in_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_mode,
  output logic [TAG_W-1:0]      out_tag,
  output logic [LANES*W-1:0]    out_c,
  output logic [LANES*W-1:0]    out_d,
  output logic                  busy
);

  localparam logic [1:0] M_NTT    = 2'b00;
  localparam logic [1:0] M_INTT   = 2'b01;
  localparam logic [1:0] M_ADDSUB = 2'b10;
  localparam logic [1:0] M_MUL    = 2'b11;
  localparam int         STG      = 5;

  function automatic logic [W:0] calc_mu();
    logic [2*W:0] num;
    logic [2*W:0] quo;
    num        = {(2*W+1){1'b0}};
    num[2*W]   = 1'b1;
    quo        = num / {{(W+1){1'b0}}, Q};
    return quo[W:0];
  endfunction

  localparam logic [W:0] MU = calc_mu();

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    s = (s >= {1'b0, Q}) ? (s - {1'b0, Q}) : s;
    return s[W-1:0];
  endfunction

  // A borrow wraps modulo 2^(W+1); adding Q then lands back inside [0,Q).
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} - {1'b0, y};
    s = (x < y) ? (s + {1'b0, Q}) : s;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_half(input logic [W-1:0] x);
    logic [W:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, Q} : {(W+1){1'b0}});
    return s[W:1];
  endfunction

  function automatic logic [W:0] barrett_q(input logic [2*W-1:0] p);
    logic [2*W+1:0] qm;
    qm = {{(W+1){1'b0}}, p[2*W-1:W-1]} * {{(W+1){1'b0}}, MU};
    return qm[2*W+1:W+1];
  endfunction

  // The quotient estimate is at most 2 low, so the remainder is below 3Q and fits W+2 bits.
  function automatic logic [W-1:0] barrett_fix(input logic [2*W-1:0] p, input logic [W:0] qt);
    logic [2*W:0] qq;
    logic [W+1:0] r;
    qq = {{W{1'b0}}, qt} * {{(W+1){1'b0}}, Q};
    r  = p[W+1:0] - qq[W+1:0];
    r  = (r >= {2'b00, Q}) ? (r - {2'b00, Q}) : r;
    r  = (r >= {2'b00, Q}) ? (r - {2'b00, Q}) : r;
    return r[W-1:0];
  endfunction

  logic                            advance;
  logic [STG-1:0]                  vld_q, vld_d;
  logic [STG-1:0][1:0]             mode_q, mode_d;
  logic [STG-1:0][TAG_W-1:0]       tag_q, tag_d;
  logic                            busy_q, busy_d;
  logic [LANES-1:0][W-1:0]         s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [LANES-1:0][W-1:0]         s1_e_q, s1_e_d, s1_f_q, s1_f_d;
  logic [LANES-1:0][2*W-1:0]       s2_p_q, s2_p_d;
  logic [LANES-1:0][W-1:0]         s2_e_q, s2_e_d, s2_f_q, s2_f_d;
  logic [LANES-1:0][2*W-1:0]       s3_p_q, s3_p_d;
  logic [LANES-1:0][W:0]           s3_qt_q, s3_qt_d;
  logic [LANES-1:0][W-1:0]         s3_e_q, s3_e_d, s3_f_q, s3_f_d;
  logic [LANES-1:0][W-1:0]         s4_m_q, s4_m_d, s4_e_q, s4_e_d, s4_f_q, s4_f_d;
  logic [LANES-1:0][W-1:0]         c_q, c_d, d_q, d_d;

  assign advance   = ~vld_q[STG-1] | out_ready;
  assign in_ready  = rst & advance;
  assign out_valid = vld_q[STG-1];
  assign out_mode  = mode_q[STG-1];
  assign out_tag   = tag_q[STG-1];
  assign out_c     = c_q;
  assign out_d     = d_q;
  assign busy      = busy_q;

  // Next contents of every stage, used only when the pipeline advances.
  always_comb begin
    logic [W-1:0] a_s, b_s, z_s, sum_s, dif_s;
    vld_d   = {vld_q[STG-2:0], in_valid & in_ready};
    mode_d  = {mode_q[STG-2:0], in_mode};
    tag_d   = {tag_q[STG-2:0], in_tag};
    busy_d  = |vld_d;
    s1_x_d  = '0;
    s1_y_d  = '0;
    s1_e_d  = '0;
    s1_f_d  = '0;
    s2_p_d  = '0;
    s2_e_d  = '0;
    s2_f_d  = '0;
    s3_p_d  = '0;
    s3_qt_d = '0;
    s3_e_d  = '0;
    s3_f_d  = '0;
    s4_m_d  = '0;
    s4_e_d  = '0;
    s4_f_d  = '0;
    c_d     = '0;
    d_d     = '0;
    for (int i = 0; i < LANES; i++) begin
      a_s   = in_a[i*W +: W];
      b_s   = in_b[i*W +: W];
      z_s   = in_z[i*W +: W];
      sum_s = mod_add(a_s, b_s);
      dif_s = mod_sub(a_s, b_s);
      // e/f carry the additive terms to the last stage; x*y feeds the shared multiplier.
      case (in_mode)
        M_NTT: begin
          s1_e_d[i] = a_s;
          s1_x_d[i] = b_s;
          s1_y_d[i] = z_s;
        end
        M_INTT: begin
          s1_e_d[i] = sum_s;
          s1_x_d[i] = dif_s;
          s1_y_d[i] = z_s;
        end
        M_ADDSUB: begin
          s1_e_d[i] = sum_s;
          s1_f_d[i] = dif_s;
        end
        M_MUL: begin
          s1_x_d[i] = a_s;
          s1_y_d[i] = b_s;
        end
        default: begin
          s1_e_d[i] = {W{1'b0}};
        end
      endcase

      s2_p_d[i]  = {{W{1'b0}}, s1_x_q[i]} * {{W{1'b0}}, s1_y_q[i]};
      s2_e_d[i]  = s1_e_q[i];
      s2_f_d[i]  = s1_f_q[i];

      s3_qt_d[i] = barrett_q(s2_p_q[i]);
      s3_p_d[i]  = s2_p_q[i];
      s3_e_d[i]  = s2_e_q[i];
      s3_f_d[i]  = s2_f_q[i];

      s4_m_d[i]  = barrett_fix(s3_p_q[i], s3_qt_q[i]);
      s4_e_d[i]  = s3_e_q[i];
      s4_f_d[i]  = s3_f_q[i];

      case (mode_q[STG-2])
        M_NTT: begin
          c_d[i] = mod_add(s4_e_q[i], s4_m_q[i]);
          d_d[i] = mod_sub(s4_e_q[i], s4_m_q[i]);
        end
        M_INTT: begin
          c_d[i] = mod_half(s4_e_q[i]);
          d_d[i] = mod_half(s4_m_q[i]);
        end
        M_ADDSUB: begin
          c_d[i] = s4_e_q[i];
          d_d[i] = s4_f_q[i];
        end
        M_MUL: begin
          c_d[i] = s4_m_q[i];
          d_d[i] = {W{1'b0}};
        end
        default: begin
          c_d[i] = {W{1'b0}};
          d_d[i] = {W{1'b0}};
        end
      endcase
    end
  end

  // Stage registers: cleared by reset, all held together while the output is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      mode_q  <= '0;
      tag_q   <= '0;
      busy_q  <= 1'b0;
      s1_x_q  <= '0;
      s1_y_q  <= '0;
      s1_e_q  <= '0;
      s1_f_q  <= '0;
      s2_p_q  <= '0;
      s2_e_q  <= '0;
      s2_f_q  <= '0;
      s3_p_q  <= '0;
      s3_qt_q <= '0;
      s3_e_q  <= '0;
      s3_f_q  <= '0;
      s4_m_q  <= '0;
      s4_e_q  <= '0;
      s4_f_q  <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else if (advance) begin
      vld_q   <= vld_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
      s1_x_q  <= s1_x_d;
      s1_y_q  <= s1_y_d;
      s1_e_q  <= s1_e_d;
      s1_f_q  <= s1_f_d;
      s2_p_q  <= s2_p_d;
      s2_e_q  <= s2_e_d;
      s2_f_q  <= s2_f_d;
      s3_p_q  <= s3_p_d;
      s3_qt_q <= s3_qt_d;
      s3_e_q  <= s3_e_d;
      s3_f_q  <= s3_f_d;
      s4_m_q  <= s4_m_d;
      s4_e_q  <= s4_e_d;
      s4_f_q  <= s4_f_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

endmodule

// File: tb/tb_ntt_bu_pipe.sv
// Directed and random checks of ntt_bu_pipe against a plain mod-Q arithmetic model.
module tb_ntt_bu_pipe;

  localparam int LANES = 2;
  localparam int W = 25;
  localparam int TAG_W = 10;
  localparam logic [W-1:0] Q = 25'h1FC0001;
  localparam longint unsigned QL = 64'(Q);
  localparam int NRAND = 10000;

  typedef struct packed {
    logic [1:0]         mode;
    logic [TAG_W-1:0]   tag;
    logic [LANES*W-1:0] c;
    logic [LANES*W-1:0] d;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_mode;
  logic [TAG_W-1:0]     in_tag;
  logic [LANES*W-1:0]   in_a, in_b, in_z;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_mode;
  logic [TAG_W-1:0]     out_tag;
  logic [LANES*W-1:0]   out_c, out_d;
  logic                 busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_out  = 0;
  exp_t sb[$];

  // Directed vectors with hand-computed results (same operands in both lanes).
  logic [1:0]       dm [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
  logic [W-1:0]     da [5] = '{25'd5, 25'd5, 25'd1, 25'd0, 25'h1FC0000};
  logic [W-1:0]     db [5] = '{25'd3, 25'd3, 25'd0, 25'd1, 25'h1FC0000};
  logic [W-1:0]     dz [5] = '{25'd2, 25'd4, 25'd1, 25'd0, 25'd0};
  logic [W-1:0]     dc [5] = '{25'hB, 25'd4, 25'hFE0001, 25'd1, 25'd1};
  logic [W-1:0]     dd [5] = '{25'h1FC0000, 25'd4, 25'hFE0001, 25'h1FC0000, 25'd0};
  logic [TAG_W-1:0] dt [5] = '{10'h2A, 10'h2B, 10'h2C, 10'h2D, 10'h2E};

  ntt_bu_pipe #(.LANES(LANES), .W(W), .Q(Q), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_tag(in_tag),
    .in_a(in_a), .in_b(in_b), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_tag(out_tag),
    .out_c(out_c), .out_d(out_d), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic longint unsigned hf(input longint unsigned x);
    return (x % 64'd2 == 64'd0) ? x / 64'd2 : (x + QL) / 64'd2;
  endfunction

  function automatic exp_t model_beat(input logic [1:0] m, input logic [TAG_W-1:0] t,
                                      input logic [LANES*W-1:0] a, input logic [LANES*W-1:0] b,
                                      input logic [LANES*W-1:0] z);
    exp_t r;
    longint unsigned la, lb, lz, lc, ld, pr;
    r.mode = m;
    r.tag  = t;
    r.c    = '0;
    r.d    = '0;
    for (int l = 0; l < LANES; l++) begin
      la = 64'(a[l*W +: W]);
      lb = 64'(b[l*W +: W]);
      lz = 64'(z[l*W +: W]);
      case (m)
        2'd0: begin
          pr = (lb * lz) % QL;
          lc = (la + pr) % QL;
          ld = (la + QL - pr) % QL;
        end
        2'd1: begin
          lc = hf((la + lb) % QL);
          ld = hf((((la + QL - lb) % QL) * lz) % QL);
        end
        2'd2: begin
          lc = (la + lb) % QL;
          ld = (la + QL - lb) % QL;
        end
        default: begin
          lc = (la * lb) % QL;
          ld = 64'd0;
        end
      endcase
      r.c[l*W +: W] = W'(lc);
      r.d[l*W +: W] = W'(ld);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(7))
      0: return {W{1'b0}};
      1: return Q - 25'd1;
      default: return W'($urandom_range(32'(Q) - 32'd1));
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dir(input int k);
    in_valid = 1'b1;
    in_mode  = dm[k];
    in_tag   = dt[k];
    in_a     = {LANES{da[k]}};
    in_b     = {LANES{db[k]}};
    in_z     = {LANES{dz[k]}};
  endtask

  task automatic drive_rnd(input logic [TAG_W-1:0] t);
    in_mode = 2'($urandom_range(3));
    in_tag  = t;
    for (int l = 0; l < LANES; l++) begin
      in_a[l*W +: W] = rnd_op();
      in_b[l*W +: W] = rnd_op();
      in_z[l*W +: W] = rnd_op();
    end
  endtask

  // Scoreboard: records accepted beats, checks emitted beats, order, range and stall hold.
  initial begin : monitor
    exp_t e;
    logic hold_prev;
    logic [LANES*W-1:0] prev_c, prev_d;
    logic [TAG_W-1:0] prev_tag;
    logic [1:0] prev_mode;
    hold_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb.delete();
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_tag", 64'(out_tag), 64'(prev_tag));
          chk("hold_mode", 64'(out_mode), 64'(prev_mode));
          chk("hold_c", 64'(out_c), 64'(prev_c));
          chk("hold_d", 64'(out_d), 64'(prev_d));
        end
        if (in_valid && in_ready) sb.push_back(model_beat(in_mode, in_tag, in_a, in_b, in_z));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("spurious_out_valid", 64'(out_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("sb_tag", 64'(out_tag), 64'(e.tag));
            chk("sb_mode", 64'(out_mode), 64'(e.mode));
            chk("sb_c", 64'(out_c), 64'(e.c));
            chk("sb_d", 64'(out_d), 64'(e.d));
            for (int l = 0; l < LANES; l++) begin
              chk("c_below_q", 64'(out_c[l*W +: W] < Q), 64'd1);
              chk("d_below_q", 64'(out_d[l*W +: W] < Q), 64'd1);
            end
            n_out++;
          end
        end
        hold_prev = out_valid && !out_ready;
        prev_c    = out_c;
        prev_d    = out_d;
        prev_tag  = out_tag;
        prev_mode = out_mode;
      end
    end
  end

  initial begin : stim
    int base, sent, stalls, cycles;
    logic acc;
    logic [TAG_W-1:0] t;

    rst = 1'b0;
    in_valid = 1'b0;
    in_mode = 2'd0;
    in_tag = '0;
    in_a = '0;
    in_b = '0;
    in_z = '0;
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_c", 64'(out_c), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b1;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Directed beats back to back: results at cycles 5..9, no gap, in order.
    for (int n = 0; n < 12; n++) begin
      if (n < 5) drive_dir(n);
      else in_valid = 1'b0;
      @(negedge clk);
      chk("dir_in_ready", 64'(in_ready), 64'd1);
      chk("dir_out_valid", 64'(out_valid), 64'(n >= 5 && n < 10));
      if (n >= 5 && n < 10) begin
        chk("dir_tag", 64'(out_tag), 64'(dt[n-5]));
        chk("dir_mode", 64'(out_mode), 64'(dm[n-5]));
        chk("dir_c", 64'(out_c), 64'({LANES{dc[n-5]}}));
        chk("dir_d", 64'(out_d), 64'({LANES{dd[n-5]}}));
      end
      cyc();
    end
    chk("dir_busy_idle", 64'(busy), 64'd0);

    // Eight beats, output stalled for three cycles while tag 2 is presented.
    base = n_out;
    sent = 0;
    stalls = 0;
    cycles = 0;
    while (n_out - base < 8 && cycles < 80) begin
      in_valid = (sent < 8);
      t = TAG_W'(sent);
      if (sent < 8) drive_rnd(t);
      if (out_valid && out_tag == 10'd2 && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      chk("stall_in_ready", 64'(in_ready), 64'(out_ready));
      if (!out_ready) chk("stall_tag", 64'(out_tag), 64'd2);
      cyc();
      if (acc) sent++;
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall_cycles", 64'(stalls), 64'd3);
    chk("stall_count", 64'(n_out - base), 64'd8);

    // Reset while four beats are in flight.
    for (int n = 0; n < 6; n++) begin
      if (n < 4) drive_rnd(TAG_W'(100 + n));
      in_valid = (n < 4);
      if (n < 5) cyc();
    end
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    chk("async_out_c", 64'(out_c), 64'd0);
    chk("async_out_d", 64'(out_d), 64'd0);
    chk("async_out_tag", 64'(out_tag), 64'd0);
    chk("async_out_mode", 64'(out_mode), 64'd0);
    cyc();
    cyc();
    rst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("no_stale", 64'(out_valid), 64'd0);
      cyc();
    end
    for (int n = 0; n < 7; n++) begin
      in_valid = (n == 0);
      if (n == 0) drive_rnd(10'h155);
      @(negedge clk);
      chk("post_rst_latency", 64'(out_valid), 64'(n == 5));
      cyc();
    end

    // Random traffic with random back-pressure.
    base = n_out;
    sent = 0;
    cycles = 0;
    while (n_out - base < NRAND && cycles < 60000) begin
      in_valid = (sent < NRAND) && ($urandom_range(3) != 0);
      drive_rnd(TAG_W'(sent));
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      cyc();
      if (acc) sent++;
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_count", 64'(n_out - base), 64'(NRAND));
    repeat (8) cyc();
    chk("rand_sb_empty", 64'(sb.size()), 64'd0);
    chk("rand_busy_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
